float_convert: RTL and testbench
================================

# float_convert

Pipelined IEEE-754 format converter between the packed HALF, SINGLE and DOUBLE float types of the FPU type package. It sits directly upstream of every FPU arithmetic stage that consumes a `float_t`: it widens or narrows an operand into the format the consumer expects and reports exception flags. It is a 2-stage pipeline with valid/ready handshakes on both sides and a throughput of one conversion per cycle.

## Interface
Parameters: none. The format encoding is fixed by `floatType_t`: HALF=2'd0, SINGLE=2'd1, DOUBLE=2'd2, and 2'd3 is illegal.

- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input conversion request
- in_ready  out  1  block can accept input this cycle
- in_type  in  2  source format
- in_value  in  64  source bits, right-aligned (HALF in [15:0], SINGLE in [31:0]); upper bits ignored
- in_target  in  2  destination format, sampled with the input
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_type  out  2  destination format (echo of in_target; 2'd0 for illegal requests)
- out_value  out  64  result, right-aligned, unused upper bits 0
- out_flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- **Transfer rule:** a transfer occurs on a cycle where valid && ready.
- **Stage 1 (unpack):**
  - Classify the input as zero, subnormal, normal, inf, qNaN or sNaN.
  - Produce sign, a signed 13-bit unbiased exponent and a 53-bit significand with the hidden bit explicit.
  - Subnormal inputs are normalised exactly using a leading-zero count.
  - Biases: HALF 15, SINGLE 127, DOUBLE 1023.
- **Stage 2 (repack):**
  - Round to nearest, ties to even, at the target fraction width (10/23/52).
  - A rounding carry increments the exponent.
- **Same format (in_type == in_target):** bit-exact passthrough, flags 0, NaNs included.
- **Widening:** always exact. Normals, zeros and infs are mapped directly. Subnormal sources become normals. Flags are 0 except for NaN handling.
- **Narrowing:**
  - Rounded exponent > target emax: result is ±Inf, with overflow=1 and inexact=1.
  - Rounded result < target min normal and nonzero: flush to signed zero, with underflow=1 and inexact=1. The converter never emits a subnormal.
  - Any discarded nonzero bit sets inexact.
- **NaN (any format change):** output is the canonical quiet NaN of the target format with the sign preserved: exponent all ones, fraction MSB 1, rest 0. invalid=1 only if the source was signalling (fraction MSB 0).
- **Zero and Inf:** sign is preserved; no flags.
- **Illegal in_type or in_target (2'd3):** out_value=0, out_type=0, flags=4'b1000.

## Timing
- **Reset:**
  - Pipeline valids clear.
  - out_valid=0, out_value=0, out_type=0, out_flags=0.
  - in_ready=1 in the first cycle after reset deasserts.
- **Latency:** a result is on out_* 2 cycles after its input transfer, when unstalled.
- **Stall propagation:**
  - stage2_advance = !out_valid || out_ready.
  - in_ready = !s1_valid || stage2_advance.
  - No combinational path from in_valid to in_ready.
- **Output stability:** while out_valid && !out_ready, out_value, out_type and out_flags are held stable.
- **Capacity:** at most 2 conversions are in flight. Order is strictly preserved, with no drops or duplicates.
- **Same-cycle output and input:** an output transfer and an input transfer in the same cycle are both honoured when the pipe is full.
- **Reset mid-operation:** all in-flight conversions are discarded; there is no output for them after reset.

## Test plan
- **Basic conversions:**
  - SINGLE 0x3F800000 → DOUBLE gives 0x3FF0000000000000.
  - The same input → HALF gives 0x3C00.
  - Both have flags 0, and out_valid rises exactly 2 cycles after the transfer.
- **Subnormal widening:** HALF 0x0001 → SINGLE gives 0x33800000, flags 0.
- **Narrowing with rounding:**
  - DOUBLE 0x3FF0000010000000 → SINGLE gives 0x3F800000 (tie to even), flags 4'b0001.
  - DOUBLE 0x3FF0000030000000 → SINGLE gives 0x3F800002, flags 4'b0001.
  - SINGLE 0x477FF000 (65520) → HALF gives 0x7C00, flags 4'b0101.
  - DOUBLE 0x3800000000000000 → SINGLE gives 0x00000000, flags 4'b0011.
- **NaN and illegal formats:**
  - SINGLE sNaN 0x7F800001 → DOUBLE gives 0x7FF8000000000000, flags 4'b1000.
  - HALF qNaN 0xFE00 → SINGLE gives 0xFFC00000, flags 0.
  - in_type=2'd3 gives out_value=0, flags 4'b1000.
- **Backpressure:**
  - Hold out_ready=0 while offering 3 back-to-back inputs.
  - Exactly 2 are accepted, and in_ready is low on the third.
  - Release out_ready: all 3 results emerge in order, with no gaps beyond 1 per cycle.
  - out_value stays stable while stalled.
- **Reset mid-flight:**
  - Assert rst_n=0 with 2 conversions in flight.
  - out_valid=0 and all outputs are 0 on the next cycle.
  - No stale result appears after rst_n returns high.

Source files
------------

// File: rtl/float_convert_if.sv
// float_convert_if: request and result handshake bundle for the float format converter
interface float_convert_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [63:0] in_value;
  logic [1:0]  in_target;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_type;
  logic [63:0] out_value;
  logic [3:0]  out_flags;
  modport master (
    output in_valid, in_type, in_value, in_target, out_ready,
    input  in_ready, out_valid, out_type, out_value, out_flags
  );
  modport slave (
    input  in_valid, in_type, in_value, in_target, out_ready,
    output in_ready, out_valid, out_type, out_value, out_flags
  );
endinterface

// File: rtl/float_convert.sv
// float_convert: 2-stage IEEE-754 HALF/SINGLE/DOUBLE converter (unpack, then round-to-nearest-even repack)
module float_convert (
  input logic clk,
  input logic rst_n,
  float_convert_if.slave bus
);
  typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_QNAN, C_SNAN} cls_t;
  function automatic logic [5:0] frac_w(input logic [1:0] t);
    return t == 2'd0 ? 6'd10 : t == 2'd1 ? 6'd23 : 6'd52;
  endfunction
  function automatic logic [12:0] bias(input logic [1:0] t);
    return t == 2'd0 ? 13'd15 : t == 2'd1 ? 13'd127 : 13'd1023;
  endfunction
  function automatic logic [10:0] emax_f(input logic [1:0] t);
    return t == 2'd0 ? 11'd31 : t == 2'd1 ? 11'd255 : 11'd2047;
  endfunction
  function automatic logic [63:0] pack(input logic [1:0] t, input logic s, input logic [10:0] e,
                                       input logic [51:0] f);
    return t == 2'd0 ? {48'd0, s, e[4:0], f[9:0]} : t == 2'd1 ? {32'd0, s, e[7:0], f[22:0]} : {s, e, f};
  endfunction
  logic [1:0]  ty;
  logic [63:0] v;
  logic        sgn;
  logic [10:0] ef;
  logic [51:0] fa;
  logic [5:0]  lz;
  logic [12:0] ex;
  logic [52:0] sg;
  logic [63:0] raw;
  cls_t        cls;
  // fraction is left-aligned to 52 bits so one normaliser serves every source width
  always_comb begin
    ty = bus.in_type;
    v = bus.in_value;
    sgn = ty == 2'd0 ? v[15] : ty == 2'd1 ? v[31] : v[63];
    ef = ty == 2'd0 ? {6'd0, v[14:10]} : ty == 2'd1 ? {3'd0, v[30:23]} : v[62:52];
    fa = ty == 2'd0 ? {v[9:0], 42'd0} : ty == 2'd1 ? {v[22:0], 29'd0} : v[51:0];
    raw = ty == 2'd0 ? {48'd0, v[15:0]} : ty == 2'd1 ? {32'd0, v[31:0]} : v;
    lz = 6'd0;
    for (int i = 0; i < 52; i++)
      if (fa[i]) lz = 6'(51 - i);
    cls = ef == emax_f(ty) ? (fa == 52'd0 ? C_INF : fa[51] ? C_QNAN : C_SNAN)
        : ef == 11'd0 ? (fa == 52'd0 ? C_ZERO : C_SUB) : C_NORM;
    ex = cls == C_SUB ? 13'd0 - bias(ty) - {7'd0, lz} : {2'd0, ef} - bias(ty);
    sg = cls == C_SUB ? {1'b0, fa} << (lz + 6'd1) : {1'b1, fa};
  end
  logic        s1_valid, s1_same, s1_ill, s1_sign;
  logic [1:0]  s1_tgt;
  logic [12:0] s1_exp;
  logic [52:0] s1_sig;
  logic [63:0] s1_raw;
  cls_t        s1_cls;
  logic [5:0]  fw, sh;
  logic [52:0] kept, rem, half;
  logic        up, carry, ovf, unf, nan;
  logic [53:0] rnd;
  logic [13:0] be;
  logic [51:0] fr, nanf;
  logic [63:0] nv;
  logic [3:0]  nf;
  logic [1:0]  nt;
  always_comb begin
    fw = frac_w(s1_tgt);
    sh = 6'd52 - fw;
    kept = s1_sig >> sh;
    rem = s1_sig & ((53'd1 << sh) - 53'd1);
    half = (53'd1 << sh) >> 1;
    up = rem != 53'd0 && (rem > half || (rem == half && kept[0]));
    rnd = {1'b0, kept} + {53'd0, up};
    carry = |(rnd >> (fw + 6'd1));
    be = {s1_exp[12], s1_exp} + {13'd0, carry} + {1'b0, bias(s1_tgt)};
    ovf = !be[13] && be >= {3'd0, emax_f(s1_tgt)};
    unf = be[13] || be == 14'd0;
    fr = rnd[51:0] & ((52'd1 << fw) - 52'd1);
    nanf = 52'd1 << (fw - 6'd1);
    nan = s1_cls == C_QNAN || s1_cls == C_SNAN;
    nt = s1_ill ? 2'd0 : s1_tgt;
    nv = s1_ill ? 64'd0 : s1_same ? s1_raw
       : nan ? pack(s1_tgt, s1_sign, 11'h7ff, nanf)
       : s1_cls == C_ZERO ? pack(s1_tgt, s1_sign, 11'd0, 52'd0)
       : s1_cls == C_INF || ovf ? pack(s1_tgt, s1_sign, 11'h7ff, 52'd0)
       : unf ? pack(s1_tgt, s1_sign, 11'd0, 52'd0)
       : pack(s1_tgt, s1_sign, be[10:0], fr);
    nf = s1_ill ? 4'b1000 : s1_same ? 4'b0000
       : nan ? {s1_cls == C_SNAN, 3'b000}
       : s1_cls == C_ZERO || s1_cls == C_INF ? 4'b0000
       : ovf ? 4'b0101 : unf ? 4'b0011 : {3'b000, rem != 53'd0};
  end
  logic adv;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || adv;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_value <= 64'd0;
      bus.out_type <= 2'd0;
      bus.out_flags <= 4'd0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (bus.in_ready && bus.in_valid) begin
        s1_tgt <= bus.in_target;
        s1_same <= bus.in_type == bus.in_target;
        s1_ill <= bus.in_type == 2'd3 || bus.in_target == 2'd3;
        s1_sign <= sgn;
        s1_exp <= ex;
        s1_sig <= sg;
        s1_raw <= raw;
        s1_cls <= cls;
      end
      if (adv) bus.out_valid <= s1_valid;
      if (adv && s1_valid) begin
        bus.out_value <= nv;
        bus.out_type <= nt;
        bus.out_flags <= nf;
      end
    end
  end
endmodule

// File: tb/tb_float_convert.sv
// tb_float_convert: directed vectors, backpressure/reset sequences and a randomized scoreboard run
module tb_float_convert;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  float_convert_if bus();
  float_convert dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {logic [1:0] st; logic [1:0] tt; logic [63:0] v; logic [63:0] ev; logic [3:0] ef; logic [1:0] et;} vec_t;
  typedef struct {logic [63:0] v; logic [3:0] f; logic [1:0] t;} exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic prev_stall = 1'b0;
  logic [63:0] prev_v;
  logic [5:0] prev_ft;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic int fwid(input logic [1:0] t);
    return t == 2'd0 ? 10 : t == 2'd1 ? 23 : 52;
  endfunction
  function automatic int ewid(input logic [1:0] t);
    return t == 2'd0 ? 5 : t == 2'd1 ? 8 : 11;
  endfunction
  function automatic logic [63:0] enc(input logic [1:0] t, input logic s, input int e, input logic [63:0] f);
    return ({63'd0, s} << (ewid(t) + fwid(t))) | (64'(e) << fwid(t)) | f;
  endfunction

  // value = m * 2^xe as an integer pair, then re-rounded to the target width
  function automatic exp_t model(input logic [1:0] st, input logic [1:0] tt, input logic [63:0] v);
    exp_t r;
    int fw, ew, b, twf, tb, tmax, e, p, sh, xe;
    logic [63:0] src, f, m, q, rm, hv;
    logic s;
    r.v = 64'd0; r.f = 4'd0; r.t = tt;
    if (st == 2'd3 || tt == 2'd3) begin
      r.f = 4'b1000; r.t = 2'd0;
      return r;
    end
    fw = fwid(st); ew = ewid(st); b = (1 << (ew - 1)) - 1;
    src = st == 2'd2 ? v : v & ((64'd1 << (1 + ew + fw)) - 64'd1);
    if (st == tt) begin
      r.v = src;
      return r;
    end
    twf = fwid(tt); tb = (1 << (ewid(tt) - 1)) - 1; tmax = 2 * tb + 1;
    s = src[ew + fw];
    e = int'((src >> fw) & ((64'd1 << ew) - 64'd1));
    f = src & ((64'd1 << fw) - 64'd1);
    if (e == 2 * b + 1) begin
      if (f != 0) begin
        r.f = f[fw - 1] ? 4'b0000 : 4'b1000;
        r.v = enc(tt, s, tmax, 64'd1 << (twf - 1));
      end else r.v = enc(tt, s, tmax, 64'd0);
      return r;
    end
    if (e == 0 && f == 0) begin
      r.v = enc(tt, s, 0, 64'd0);
      return r;
    end
    m = e == 0 ? f : f | (64'd1 << fw);
    xe = (e == 0 ? 1 : e) - b - fw;
    p = 63;
    while (!m[p]) p--;
    sh = p - twf;
    xe = xe + p;
    if (sh > 0) begin
      q = m >> sh; rm = m & ((64'd1 << sh) - 64'd1); hv = 64'd1 << (sh - 1);
      if (rm > hv || (rm == hv && q[0])) q++;
      if (rm != 0) r.f[0] = 1'b1;
    end else q = m << (-sh);
    if ((q >> (twf + 1)) != 0) begin
      q = q >> 1; xe++;
    end
    if (xe + tb >= tmax) begin
      r.v = enc(tt, s, tmax, 64'd0); r.f = 4'b0101;
    end else if (xe + tb <= 0) begin
      r.v = enc(tt, s, 0, 64'd0); r.f = 4'b0011;
    end else r.v = enc(tt, s, xe + tb, q & ((64'd1 << twf) - 64'd1));
    return r;
  endfunction

  task automatic drive(input logic vl, input logic [1:0] st, input logic [1:0] tt, input logic [63:0] v);
    bus.in_valid = vl; bus.in_type = st; bus.in_target = tt; bus.in_value = v;
  endtask

  // called at a falling edge with inputs already driven; advances to the next falling edge
  task automatic step();
    exp_t x;
    #1;
    if (prev_stall) begin
      chk("stall_hold_value", bus.out_value, prev_v);
      chk("stall_hold_type_flags", {bus.out_type, bus.out_flags}, prev_ft);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected: got %0h want none", bus.out_value);
      end else begin
        x = sb.pop_front();
        chk("sb_value", bus.out_value, x.v);
        chk("sb_flags", bus.out_flags, x.f);
        chk("sb_type", bus.out_type, x.t);
      end
    end
    if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_type, bus.in_target, bus.in_value));
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_v = bus.out_value;
    prev_ft = {bus.out_type, bus.out_flags};
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_val(input logic [1:0] t);
    logic [63:0] v;
    int md, ew, fw, b, ee;
    v = {$urandom, $urandom};
    md = $urandom_range(0, 6);
    ew = ewid(t); fw = fwid(t); b = (1 << (ew - 1)) - 1;
    ee = md == 0 ? 0 : md == 1 ? 2 * b + 1 : b + int'($urandom_range(0, 60)) - 30;
    if (md >= 2) ee = ee < 1 ? 1 : ee > 2 * b ? 2 * b : ee;
    if (md <= 4) v = (v & ~(((64'd1 << ew) - 64'd1) << fw)) | (64'(ee) << fw);
    if ($urandom_range(0, 2) == 0) v = v & ({64{1'b1}} << $urandom_range(0, 40));
    return v;
  endfunction

  initial begin
    exp_t bp[3];
    drive(1'b0, 2'd0, 2'd0, 64'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_value", bus.out_value, 64'd0);
    chk("rst_out_type", bus.out_type, 2'd0);
    chk("rst_out_flags", bus.out_flags, 4'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    vecs.push_back(vec_t'{2'd1, 2'd2, 64'h3F800000, 64'h3FF0000000000000, 4'h0, 2'd2});
    vecs.push_back(vec_t'{2'd1, 2'd0, 64'h3F800000, 64'h3C00, 4'h0, 2'd0});
    vecs.push_back(vec_t'{2'd0, 2'd1, 64'h0001, 64'h33800000, 4'h0, 2'd1});
    vecs.push_back(vec_t'{2'd2, 2'd1, 64'h3FF0000010000000, 64'h3F800000, 4'h1, 2'd1});
    vecs.push_back(vec_t'{2'd2, 2'd1, 64'h3FF0000030000000, 64'h3F800002, 4'h1, 2'd1});
    vecs.push_back(vec_t'{2'd1, 2'd0, 64'h477FF000, 64'h7C00, 4'h5, 2'd0});
    vecs.push_back(vec_t'{2'd2, 2'd1, 64'h3800000000000000, 64'h0, 4'h3, 2'd1});
    vecs.push_back(vec_t'{2'd1, 2'd2, 64'h7F800001, 64'h7FF8000000000000, 4'h8, 2'd2});
    vecs.push_back(vec_t'{2'd0, 2'd1, 64'hFE00, 64'hFFC00000, 4'h0, 2'd1});
    vecs.push_back(vec_t'{2'd3, 2'd2, 64'h3F800000, 64'h0, 4'h8, 2'd0});
    vecs.push_back(vec_t'{2'd1, 2'd3, 64'h3F800000, 64'h0, 4'h8, 2'd0});
    vecs.push_back(vec_t'{2'd2, 2'd2, 64'h7FF0000000000001, 64'h7FF0000000000001, 4'h0, 2'd2});
    vecs.push_back(vec_t'{2'd1, 2'd0, 64'hFF800000, 64'hFC00, 4'h0, 2'd0});
    vecs.push_back(vec_t'{2'd2, 2'd0, 64'h8000000000000000, 64'h8000, 4'h0, 2'd0});
    vecs.push_back(vec_t'{2'd1, 2'd2, 64'hDEADBEEF3F800000, 64'h3FF0000000000000, 4'h0, 2'd2});
    vecs.push_back(vec_t'{2'd0, 2'd2, 64'h03FF, 64'h3F0FF80000000000, 4'h0, 2'd2});
    vecs.push_back(vec_t'{2'd2, 2'd1, 64'h0000000000000001, 64'h0, 4'h3, 2'd1});
    vecs.push_back(vec_t'{2'd0, 2'd1, 64'h7BFF, 64'h477FE000, 4'h0, 2'd1});
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].st, vecs[i].tt, vecs[i].v);
      #1 chk($sformatf("vec%0d_in_ready", i), bus.in_ready, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk($sformatf("vec%0d_latency1", i), bus.out_valid, 1'b0);
      @(negedge clk); #1;
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d_value", i), bus.out_value, vecs[i].ev);
      chk($sformatf("vec%0d_flags", i), bus.out_flags, vecs[i].ef);
      chk($sformatf("vec%0d_type", i), bus.out_type, vecs[i].et);
      @(negedge clk);
    end

    for (int i = 0; i < 800; i++) begin
      logic [1:0] st, tt;
      st = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      tt = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      drive($urandom_range(0, 3) != 0, st, tt, rand_val(st));
      bus.out_ready = $urandom_range(0, 2) != 0;
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() > 0; k++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    step();

    bp[0] = '{64'h3F800000, 4'h0, 2'd2};
    bp[1] = '{64'h3F800000, 4'h0, 2'd0};
    bp[2] = '{64'h0001, 4'h0, 2'd1};
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, k == 0 ? 2'd1 : k == 1 ? 2'd1 : 2'd0, bp[k].t, bp[k].v);
      #1 chk($sformatf("bp_in_ready%0d", k), bus.in_ready, k < 2);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_stalled_in_ready", bus.in_ready, 1'b0);
      chk("bp_stalled_value", bus.out_value, 64'h3FF0000000000000);
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp_stream_valid%0d", k), bus.out_valid, 1'b1);
      step();
      bus.in_valid = 1'b0;
    end
    #1 chk("bp_after_valid", bus.out_valid, 1'b0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);

    bus.out_ready = 1'b0;
    drive(1'b1, 2'd2, 2'd1, 64'h3FF0000030000000);
    step();
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_value", bus.out_value, 64'd0);
    chk("midrst_out_type", bus.out_type, 2'd0);
    chk("midrst_out_flags", bus.out_flags, 4'd0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    sb.delete();
    prev_stall = 1'b0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("midrst_no_stale", bus.out_valid, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
